// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC owner, instruction memory fetch and downstream issue
module instr_fetch_unit #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               run,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [3:0]         opcode,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_addr
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] pc;
    // Blanks the request for one cycle after a redirect lands in FETCH, so the
    // memory sees a clean gap between the wrong-path and the new request.
    logic              squash;

    assign imem_req  = (state == FETCH) && !squash;
    assign imem_addr = pc;
    assign opcode    = instr[INSTR_W-1 -: 4];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            pc          <= '0;
            squash      <= 1'b0;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
        end else begin
            squash <= 1'b0;
            if (redirect_valid) begin
                pc          <= redirect_addr;
                instr_valid <= 1'b0;
                state       <= run ? FETCH : IDLE;
                if (state == FETCH) begin
                    squash <= run;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (run) begin
                            state <= FETCH;
                        end
                    end
                    FETCH: begin
                        if (imem_req && imem_ack) begin
                            instr       <= imem_rdata;
                            instr_pc    <= pc;
                            pc          <= pc + 1'b1;
                            instr_valid <= 1'b1;
                            state       <= HOLD;
                        end
                    end
                    HOLD: begin
                        if (instr_valid && instr_ready) begin
                            instr_valid <= 1'b0;
                            state       <= run ? FETCH : IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - randomized bench for instr_fetch_unit against an address/issue model
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        run;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [3:0]  opcode;
    logic [7:0]  instr_pc;
    logic        redirect_valid;
    logic [7:0]  redirect_addr;

    instr_fetch_unit #(.ADDR_W(8), .INSTR_W(16)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .run            (run),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .opcode         (opcode),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Model: instruction memory contents plus the address stream the unit must follow.
    logic [15:0] mem [256];
    int exp_pc;
    int exp_issue;
    int issued;
    bit pend_lat, pend_drop, pend_kill, hold_chk;

    int redir_pct, ready_pct, ack_pct, spur_pct;
    bit force_redir;
    logic [7:0] force_tgt;
    bit redir_on_ack;
    logic [7:0] roa_tgt;

    task automatic model_reset();
        exp_pc    = 0;
        exp_issue = 0;
        pend_lat  = 0;
        pend_drop = 0;
        pend_kill = 0;
        hold_chk  = 0;
    endtask

    // Called at a falling edge: check what the last rising edge produced, then drive the next one.
    task automatic step();
        bit rd, rdy, ak;
        logic [7:0] tgt;
        if (pend_lat)  check("valid_lat", instr_valid, 1);
        if (pend_drop) check("redir_drop", imem_req, 0);
        if (pend_kill) check("redir_kill", instr_valid, 0);
        if (imem_req) begin
            check("fetch_addr", imem_addr, exp_pc);
            check("req_vs_valid", instr_valid, 0);
        end
        if (hold_chk) begin
            check("hold_valid", instr_valid, 1);
            check("hold_noreq", imem_req, 0);
            check("hold_instr", instr, mem[exp_issue]);
            check("hold_pc", instr_pc, exp_issue);
        end
        pend_lat  = 0;
        pend_drop = 0;
        pend_kill = 0;

        rd  = $urandom_range(0, 99) < redir_pct;
        tgt = 8'($urandom);
        if ($urandom_range(0, 3) == 0) tgt = 8'hFF;
        if (force_redir) begin
            rd = 1;
            tgt = force_tgt;
            force_redir = 0;
        end
        rdy = $urandom_range(0, 99) < ready_pct;
        if (imem_req) ak = $urandom_range(0, 99) < ack_pct;
        else          ak = $urandom_range(0, 99) < spur_pct;
        if (imem_req && ak && redir_on_ack) begin
            rd = 1;
            tgt = roa_tgt;
            redir_on_ack = 0;
        end

        redirect_valid = rd;
        redirect_addr  = tgt;
        instr_ready    = rdy;
        imem_ack       = ak;
        imem_rdata     = (imem_req && ak) ? mem[imem_addr] : 16'($urandom);

        if (instr_valid && rdy) begin
            check("issue_instr", instr, mem[exp_issue]);
            check("issue_pc", instr_pc, exp_issue);
            check("issue_opcode", opcode, mem[exp_issue][15:12]);
            issued++;
        end
        hold_chk = instr_valid && !rdy && !rd;
        if (rd) begin
            exp_pc    = tgt;
            pend_drop = imem_req;
            pend_kill = 1;
        end else if (imem_req && ak) begin
            exp_issue = exp_pc;
            exp_pc    = (exp_pc + 1) % 256;
            pend_lat  = 1;
        end
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},    imem_req, 0);
        check({tag, "_addr"},   imem_addr, 0);
        check({tag, "_valid"},  instr_valid, 0);
        check({tag, "_instr"},  instr, 0);
        check({tag, "_opcode"}, opcode, 0);
        check({tag, "_pc"},     instr_pc, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        mem[0]    = 16'h2123;
        mem[1]    = 16'h6456;
        mem[8'h40] = 16'h8A01;
        reset_n = 0; run = 0; imem_ack = 0; imem_rdata = 0;
        instr_ready = 0; redirect_valid = 0; redirect_addr = 0;
        force_redir = 0; redir_on_ack = 0; force_tgt = 0; roa_tgt = 0;
        issued = 0;
        model_reset();
        redir_pct = 0; ready_pct = 100; ack_pct = 100; spur_pct = 0;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1;
        run = 1;

        // Straight-line fetch of 0x2123 / 0x6456
        for (int i = 0; i < 12; i++) step();
        check("first_issues", issued >= 2, 1);

        // Wait states and backpressure
        ack_pct = 30; ready_pct = 15;
        for (int i = 0; i < 60; i++) step();

        // Redirect to 0x40 in the cycle the 0x05 fetch is acked
        ack_pct = 50; ready_pct = 100;
        force_redir = 1; force_tgt = 8'h05;
        step();
        redir_on_ack = 1; roa_tgt = 8'h40;
        for (int i = 0; i < 20; i++) step();

        // Wrap 0xFF -> 0x00
        force_redir = 1; force_tgt = 8'hFF;
        for (int i = 0; i < 20; i++) step();

        // Random mix
        redir_pct = 8; ready_pct = 60; ack_pct = 45; spur_pct = 10;
        for (int blk = 0; blk < 15; blk++) begin
            run = ($urandom_range(0, 4) != 0);
            for (int i = 0; i < 100; i++) step();
        end

        // Asynchronous reset in the middle of a fetch at 0x03
        run = 1; redir_pct = 0; spur_pct = 0; ack_pct = 0; ready_pct = 100;
        for (int i = 0; i < 4; i++) step();
        force_redir = 1; force_tgt = 8'h03;
        for (int i = 0; i < 4; i++) step();
        check("prereset_req", imem_req, 1);
        check("prereset_addr", imem_addr, 8'h03);
        #2;
        reset_n = 0;
        #1;
        check_reset_outputs("async");
        imem_ack = 1;
        imem_rdata = 16'hDEAD;
        redirect_valid = 0;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("stale");
        imem_ack = 0;
        reset_n = 1;
        model_reset();
        ack_pct = 100;
        for (int i = 0; i < 10; i++) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
